// File: rtl/program_loader.sv
// program_loader
//
// Boot-time program loader. It receives a byte stream, writes it into program
// memory one 32-bit word at a time, and holds the processor core in reset
// until the whole program has landed. Word addresses are byte addresses
// (word_index*4), the same addresses the core later fetches from.
//
// Stream format: LEN_LO, LEN_HI (16-bit little-endian word count N), then N
// words of four bytes each, least-significant byte first.
//
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//   When defined, a running XOR of every stream byte (length bytes included)
//   is compared against one extra checksum byte taken after the last word.
//   A mismatch ends in ERROR with the core still held in reset.
//
// Ports:
//   clk            single clock
//   reset          synchronous, active-high reset
//   Start_i        one-cycle pulse; starts a load from IDLE, DONE or ERROR
//   Byte_Data_i    incoming stream byte
//   Byte_Valid_i   Byte_Data_i is valid
//   Byte_Ready_o   loader accepts a byte this cycle (transfer = valid & ready)
//   Mem_Write_o    program-memory write strobe, one cycle per word
//   Mem_Address_o  byte address of the word being written
//   Mem_Data_o     instruction word being written
//   Cpu_Reset_o    reset to the core; low only in DONE
//   Done_o         high in DONE
//   Error_o        high in ERROR

module program_loader #(
   parameter int PROGRAM_MEMORY_DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start_i,
   input  logic [7:0]  Byte_Data_i,
   input  logic        Byte_Valid_i,
   output logic        Byte_Ready_o,
   output logic        Mem_Write_o,
   output logic [31:0] Mem_Address_o,
   output logic [31:0] Mem_Data_o,
   output logic        Cpu_Reset_o,
   output logic        Done_o,
   output logic        Error_o
);

   localparam int IDX_W = $clog2(PROGRAM_MEMORY_DEPTH + 1);

   // SETTLE covers the write cycle of the final word when no checksum byte
   // follows it, so the core never leaves reset while memory is being written.
   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      SETTLE,
      DONE,
      ERROR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      , CHECK
`endif
   } state_t;

   state_t state_q, state_d;

   logic [15:0]      length_q;
   logic [IDX_W-1:0] word_index;
   logic [1:0]       byte_count;
   logic [23:0]      shift_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]       checksum_q;
`endif

   logic        xfer;
   logic        start_load;
   logic [15:0] length_n;
   logic        last_word;

   assign xfer       = Byte_Valid_i && Byte_Ready_o;
   assign start_load = Start_i && (state_q == IDLE || state_q == DONE || state_q == ERROR);
   assign length_n   = {Byte_Data_i, length_q[7:0]};
   assign last_word  = ({{(16-IDX_W){1'b0}}, word_index} + 16'd1) == length_q;

   // State register: reset always wins over any start request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: walks the stream header, then the data words, and
   // finishes in DONE or ERROR. Start is honoured only when no load is active.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (Start_i) state_d = LEN_LO;
         end
         LEN_LO: begin
            if (xfer) state_d = LEN_HI;
         end
         LEN_HI: begin
            if (xfer) begin
               if (length_n > 16'(PROGRAM_MEMORY_DEPTH)) begin
                  state_d = ERROR;
               end else if (length_n == 16'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d = DONE;
`endif
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (xfer && byte_count == 2'd3 && last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               state_d = CHECK;
`else
               state_d = SETTLE;
`endif
            end
         end
         SETTLE: begin
            state_d = DONE;
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (xfer) state_d = (Byte_Data_i == checksum_q) ? DONE : ERROR;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Output decode: byte acceptance and the core reset depend on state only.
   always_comb begin
      Byte_Ready_o = 1'b0;
      case (state_q)
         LEN_LO, LEN_HI, DATA: Byte_Ready_o = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         CHECK:                Byte_Ready_o = 1'b1;
`endif
         default:              Byte_Ready_o = 1'b0;
      endcase
      Done_o      = (state_q == DONE);
      Error_o     = (state_q == ERROR);
      Cpu_Reset_o = (state_q != DONE);
   end

   // Datapath: captures the length, packs bytes into words and issues the
   // one-cycle write strobe the cycle after each word's fourth byte.
   // Start is only accepted in states that take no bytes, so clearing the
   // counters never collides with a byte transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         length_q      <= '0;
         word_index    <= '0;
         byte_count    <= '0;
         shift_q       <= '0;
         Mem_Write_o   <= 1'b0;
         Mem_Address_o <= '0;
         Mem_Data_o    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         checksum_q    <= '0;
`endif
      end else begin
         Mem_Write_o <= 1'b0;
         if (start_load) begin
            word_index <= '0;
            byte_count <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum_q <= '0;
`endif
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         if (xfer) checksum_q <= checksum_q ^ Byte_Data_i;
`endif
         if (xfer && state_q == LEN_LO) length_q[7:0]  <= Byte_Data_i;
         if (xfer && state_q == LEN_HI) length_q[15:8] <= Byte_Data_i;
         if (xfer && state_q == DATA) begin
            byte_count <= byte_count + 2'd1;
            case (byte_count)
               2'd0: shift_q[7:0]   <= Byte_Data_i;
               2'd1: shift_q[15:8]  <= Byte_Data_i;
               2'd2: shift_q[23:16] <= Byte_Data_i;
               default: begin
                  Mem_Data_o    <= {Byte_Data_i, shift_q};
                  Mem_Address_o <= {{(30-IDX_W){1'b0}}, word_index, 2'b00};
                  Mem_Write_o   <= 1'b1;
                  word_index    <= word_index + 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//
// Directed testbench for program_loader. Streams hand-built programs into the
// loader, records every memory write, and compares outputs against expected
// values worked out by hand. Works with or without PROGRAM_LOADER_CHECKSUM_EN;
// with the macro defined the bench appends its own XOR checksum byte.

module tb_program_loader;

   logic        clk;
   logic        reset;
   logic        startIn;
   logic [7:0]  byteData;
   logic        byteValid;
   logic        byteReady;
   logic        memWrite;
   logic [31:0] memAddress;
   logic [31:0] memData;
   logic        cpuReset;
   logic        doneOut;
   logic        errorOut;

   int          compareCount;
   int          mismatchCount;
   int          acceptCount;
   int          overlapCount;
   int          acceptBase;
   logic [7:0]  runningXor;
   logic [31:0] wrAddr[$];
   logic [31:0] wrData[$];
   logic [7:0]  toggleBytes[6];
   logic [7:0]  threeWordBytes[14];

   program_loader #(.PROGRAM_MEMORY_DEPTH(64)) dut (
      .clk           (clk),
      .reset         (reset),
      .Start_i       (startIn),
      .Byte_Data_i   (byteData),
      .Byte_Valid_i  (byteValid),
      .Byte_Ready_o  (byteReady),
      .Mem_Write_o   (memWrite),
      .Mem_Address_o (memAddress),
      .Mem_Data_o    (memData),
      .Cpu_Reset_o   (cpuReset),
      .Done_o        (doneOut),
      .Error_o       (errorOut)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Records every write strobe and flags any write made while the core is
   // already out of reset. Sampled on the falling edge, away from the writes.
   always @(negedge clk) begin
      if (memWrite) begin
         wrAddr.push_back(memAddress);
         wrData.push_back(memData);
         if (!cpuReset) overlapCount++;
      end
   end

   // Counts bytes actually consumed by the loader.
   always @(posedge clk) begin
      if (!reset && byteValid && byteReady) acceptCount++;
   end

   // Hard stop in case the run ever stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      byteValid  = 1'b1;
      byteData   = b;
      runningXor = runningXor ^ b;
      @(posedge clk);
      #1;
      byteValid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulseStart();
      startIn = 1'b1;
      @(posedge clk);
      #1;
      startIn    = 1'b0;
      runningXor = 8'h00;
   endtask

   task automatic sendChecksum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      logic [7:0] sum;
      sum = runningXor;
      applyStimulus(sum);
`endif
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      acceptCount   = 0;
      overlapCount  = 0;
      runningXor    = 8'h00;
      reset         = 1'b1;
      startIn       = 1'b0;
      byteValid     = 1'b0;
      byteData      = 8'h00;
      toggleBytes    = '{8'h01, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
      threeWordBytes = '{8'h03, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05,
                         8'h20, 8'h00, 8'h13, 8'h06, 8'h30, 8'h00};

      // Reset state after five idle cycles.
      idleCycles(2);
      reset = 1'b0;
      idleCycles(5);
      checkOutput("rst_cpu_reset", 32'(cpuReset), 32'd1);
      checkOutput("rst_ready", 32'(byteReady), 32'd0);
      checkOutput("rst_write", 32'(memWrite), 32'd0);
      checkOutput("rst_addr", memAddress, 32'd0);
      checkOutput("rst_data", memData, 32'd0);
      checkOutput("rst_done", 32'(doneOut), 32'd0);
      checkOutput("rst_error", 32'(errorOut), 32'd0);

      // Two-word program, bytes back to back.
      wrAddr.delete();
      wrData.delete();
      pulseStart();
      checkOutput("len_lo_ready", 32'(byteReady), 32'd1);
      applyStimulus(8'h02); applyStimulus(8'h00);
      applyStimulus(8'h13); applyStimulus(8'h05); applyStimulus(8'h10); applyStimulus(8'h00);
      applyStimulus(8'h93); applyStimulus(8'h05); applyStimulus(8'h20); applyStimulus(8'h00);
      checkOutput("two_last_wr_pulse", 32'(memWrite), 32'd1);
      checkOutput("two_last_wr_addr", memAddress, 32'h4);
      checkOutput("two_done_not_yet", 32'(doneOut), 32'd0);
      sendChecksum();
      idleCycles(2);
      checkOutput("two_wr_count", 32'(wrAddr.size()), 32'd2);
      if (wrAddr.size() == 2) begin
         checkOutput("two_addr0", wrAddr[0], 32'h0);
         checkOutput("two_data0", wrData[0], 32'h00100513);
         checkOutput("two_addr1", wrAddr[1], 32'h4);
         checkOutput("two_data1", wrData[1], 32'h00200593);
      end
      checkOutput("two_done", 32'(doneOut), 32'd1);
      checkOutput("two_cpu_released", 32'(cpuReset), 32'd0);
      checkOutput("two_ready_low", 32'(byteReady), 32'd0);

      // Oversized length (65 words) goes straight to ERROR.
      wrAddr.delete();
      wrData.delete();
      pulseStart();
      checkOutput("restart_clears_done", 32'(doneOut), 32'd0);
      applyStimulus(8'h41); applyStimulus(8'h00);
      checkOutput("big_error", 32'(errorOut), 32'd1);
      checkOutput("big_cpu_reset", 32'(cpuReset), 32'd1);
      checkOutput("big_ready_low", 32'(byteReady), 32'd0);
      idleCycles(2);
      checkOutput("big_no_write", 32'(wrAddr.size()), 32'd0);

      // Zero-length program completes without writing.
      pulseStart();
      checkOutput("restart_clears_error", 32'(errorOut), 32'd0);
      applyStimulus(8'h00); applyStimulus(8'h00);
      sendChecksum();
      idleCycles(1);
      checkOutput("zero_done", 32'(doneOut), 32'd1);
      checkOutput("zero_no_write", 32'(wrAddr.size()), 32'd0);

      // One word with valid toggling every other cycle, then a stray byte.
      wrAddr.delete();
      wrData.delete();
      pulseStart();
      acceptBase = acceptCount;
      foreach (toggleBytes[i]) begin
         applyStimulus(toggleBytes[i]);
         byteData = 8'hEE;
         idleCycles(1);
      end
      sendChecksum();
      idleCycles(2);
      checkOutput("tog_wr_count", 32'(wrAddr.size()), 32'd1);
      if (wrAddr.size() == 1) begin
         checkOutput("tog_addr", wrAddr[0], 32'h0);
         checkOutput("tog_data", wrData[0], 32'h00200593);
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checkOutput("tog_accepted", 32'(acceptCount - acceptBase), 32'd7);
`else
      checkOutput("tog_accepted", 32'(acceptCount - acceptBase), 32'd6);
`endif
      checkOutput("tog_done", 32'(doneOut), 32'd1);
      acceptBase = acceptCount;
      applyStimulus(8'hAA);
      idleCycles(1);
      checkOutput("stray_not_taken", 32'(acceptCount - acceptBase), 32'd0);
      checkOutput("stray_still_done", 32'(doneOut), 32'd1);

      // Reset after six data bytes of a three-word load, with Start raised too.
      pulseStart();
      for (int i = 0; i < 8; i++) applyStimulus(threeWordBytes[i]);
      reset   = 1'b1;
      startIn = 1'b1;
      @(posedge clk);
      #1;
      startIn = 1'b0;
      checkOutput("mid_rst_write", 32'(memWrite), 32'd0);
      checkOutput("mid_rst_ready", 32'(byteReady), 32'd0);
      checkOutput("mid_rst_cpu_reset", 32'(cpuReset), 32'd1);
      checkOutput("mid_rst_addr", memAddress, 32'd0);
      checkOutput("mid_rst_data", memData, 32'd0);
      reset = 1'b0;
      idleCycles(1);

      // Reset landing on the fourth byte of a word drops the pending strobe.
      pulseStart();
      applyStimulus(8'h01); applyStimulus(8'h00);
      applyStimulus(8'h13); applyStimulus(8'h05); applyStimulus(8'h10);
      reset     = 1'b1;
      byteValid = 1'b1;
      byteData  = 8'h00;
      @(posedge clk);
      #1;
      byteValid = 1'b0;
      checkOutput("drop_pending_write", 32'(memWrite), 32'd0);
      reset = 1'b0;
      idleCycles(1);

      // Full three-word load after the interrupted ones.
      wrAddr.delete();
      wrData.delete();
      pulseStart();
      foreach (threeWordBytes[i]) applyStimulus(threeWordBytes[i]);
      sendChecksum();
      idleCycles(2);
      checkOutput("three_wr_count", 32'(wrAddr.size()), 32'd3);
      if (wrAddr.size() == 3) begin
         checkOutput("three_data0", wrData[0], 32'h00100513);
         checkOutput("three_addr2", wrAddr[2], 32'h8);
         checkOutput("three_data2", wrData[2], 32'h00300613);
      end
      checkOutput("three_done", 32'(doneOut), 32'd1);

      // Maximum length: 64 words, word w = 0xA50000ww.
      wrAddr.delete();
      wrData.delete();
      pulseStart();
      applyStimulus(8'h40); applyStimulus(8'h00);
      for (int w = 0; w < 64; w++) begin
         applyStimulus(8'(w)); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'hA5);
      end
      sendChecksum();
      idleCycles(2);
      checkOutput("max_wr_count", 32'(wrAddr.size()), 32'd64);
      if (wrAddr.size() == 64) begin
         checkOutput("max_last_addr", wrAddr[63], 32'hFC);
         checkOutput("max_last_data", wrData[63], 32'hA500003F);
      end
      checkOutput("max_done", 32'(doneOut), 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      // Checksum good (0x07) then bad (0x08) on the same one-word program.
      wrAddr.delete();
      wrData.delete();
      pulseStart();
      applyStimulus(8'h01); applyStimulus(8'h00);
      applyStimulus(8'h13); applyStimulus(8'h05); applyStimulus(8'h10); applyStimulus(8'h00);
      applyStimulus(8'h07);
      idleCycles(1);
      checkOutput("ck_good_done", 32'(doneOut), 32'd1);
      wrAddr.delete();
      wrData.delete();
      pulseStart();
      applyStimulus(8'h01); applyStimulus(8'h00);
      applyStimulus(8'h13); applyStimulus(8'h05); applyStimulus(8'h10); applyStimulus(8'h00);
      applyStimulus(8'h08);
      idleCycles(1);
      checkOutput("ck_bad_error", 32'(errorOut), 32'd1);
      checkOutput("ck_bad_cpu_reset", 32'(cpuReset), 32'd1);
      checkOutput("ck_bad_wr_count", 32'(wrAddr.size()), 32'd1);
      if (wrAddr.size() == 1) begin
         checkOutput("ck_bad_addr", wrAddr[0], 32'h0);
         checkOutput("ck_bad_data", wrData[0], 32'h00100513);
      end
`endif

      checkOutput("no_write_while_core_runs", 32'(overlapCount), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
